// File: rtl/fir_alu_sequencer.sv
// fir_alu_sequencer: direct-form FIR filter built on a shared multi-cycle ALU.
// Accepts one 16-bit sample at a time, issues one multiply per tap to the ALU,
// and accumulates the 32-bit products into the filter output.
// Optional build macro FIR_SAT_EN: saturating accumulation instead of 32-bit wrap.
module fir_alu_sequencer #(
  parameter int TAPS    = 8,
  parameter int ALU_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [15:0]               coef_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               in_data,
  output logic [15:0]               alu_a,
  output logic [15:0]               alu_b,
  output logic [1:0]                alu_op_sel,
  input  logic signed [31:0]        alu_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_data,
  output logic                      busy
);

  localparam int AW = $clog2(TAPS);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [AW-1:0] K_LAST   = AW'(TAPS - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(ALU_LAT - 1);
  localparam logic [AW:0]   TAPS_W   = (AW+1)'(TAPS);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t                   st, nxt;
  logic [TAPS-1:0][15:0]    x;      // delay line, x[0] is newest sample
  logic [TAPS-1:0][15:0]    coef;
  logic [AW-1:0]            k;      // tap in flight
  logic [CW-1:0]            cnt;    // WAIT cycles elapsed for current tap
  logic signed [31:0]       acc, acc_nxt, sum;
  logic [31:0]              out_q;
  logic                     addr_ok;

  assign addr_ok  = ({1'b0, coef_addr} < TAPS_W);
  assign sum      = acc + alu_result;
  assign out_data = out_q;

`ifdef FIR_SAT_EN
  // Clamp on signed overflow: both addends share a sign the sum lost.
  always_comb begin
    acc_nxt = sum;
    if (!acc[31] && !alu_result[31] && sum[31])      acc_nxt = 32'sh7FFFFFFF;
    else if (acc[31] && alu_result[31] && !sum[31])  acc_nxt = 32'sh80000000;
  end
`else
  // Plain two's-complement wrap.
  always_comb acc_nxt = sum;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= nxt;
  end

  // Next-state and handshake/ALU outputs; operands only driven while a tap is in flight.
  always_comb begin
    nxt        = st;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    alu_a      = 16'h0;
    alu_b      = 16'h0;
    alu_op_sel = 2'b00;
    case (st)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) nxt = ISSUE;
      end
      ISSUE: begin
        alu_a      = x[k];
        alu_b      = coef[k];
        alu_op_sel = 2'b01;
        nxt        = WAIT;
      end
      WAIT: begin
        alu_a      = x[k];
        alu_b      = coef[k];
        alu_op_sel = 2'b01;
        if (cnt == LAT_LAST) nxt = (k == K_LAST) ? OUT : ISSUE;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Datapath: coefficient bank, delay line, tap/wait counters, accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x     <= '0;
      coef  <= '0;
      k     <= '0;
      cnt   <= '0;
      acc   <= '0;
      out_q <= '0;
    end else begin
      case (st)
        IDLE: begin
          // Write lands on the same edge as acceptance, so it applies to that sample.
          if (coef_we && addr_ok) coef[coef_addr] <= coef_data;
          if (in_valid) begin
            x   <= {x[TAPS-2:0], in_data};
            acc <= '0;
            k   <= '0;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (cnt == LAT_LAST) begin
            acc <= acc_nxt;
            if (k == K_LAST) out_q <= acc_nxt;
            else             k     <= k + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
